// File: rtl/meas_pkg.sv
// Shared types for the frequency-meter measurement sequencer.
package meas_pkg;

   typedef enum logic [1:0] {
      MODE_FREQ     = 2'd0,
      MODE_PERIOD   = 2'd1,
      MODE_INTERVAL = 2'd2,
      OP_SWEEP      = 2'd3
   } meas_mode_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      M_START = 3'd1,
      M_ACK   = 3'd2,
      M_RUN   = 3'd3,
      C_START = 3'd4,
      C_ACK   = 3'd5,
      C_RUN   = 3'd6,
      NEXT    = 3'd7
   } seq_state_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_ACK    = 2'd1,
      ERR_RUN    = 2'd2,
      ERR_SERIAL = 2'd3
   } err_code_e;

   // Frequency mode runs on the F engine; period and interval share the T engine.
   function automatic logic uses_f_engine(input logic [1:0] mode);
      return (mode == MODE_FREQ);
   endfunction

endpackage

// File: rtl/meas_sequencer_if.sv
// Command and engine handshake bundle between the host/engines and the sequencer.
interface meas_sequencer_if;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic       ready;
   logic [1:0] mode;
   logic       Fbusy;
   logic       Tbusy;
   logic       Cbusy;
   logic       Fstart;
   logic       Tstart;
   logic       Cstart;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   modport master (
      output cmd_valid, cmd_op, Fbusy, Tbusy, Cbusy,
      input  ready, mode, Fstart, Tstart, Cstart, done, err, err_code
   );

   modport slave (
      input  cmd_valid, cmd_op, Fbusy, Tbusy, Cbusy,
      output ready, mode, Fstart, Tstart, Cstart, done, err, err_code
   );
endinterface

// File: rtl/seq_watchdog.sv
// Loadable down-counter; expired while the count sits at zero.
module seq_watchdog #(
   parameter int W = 27
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_expired
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= {W{1'b0}};
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != {W{1'b0}}) begin
         r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
      end else begin
         r_count <= r_count;
      end
   end

   assign o_expired = (r_count == {W{1'b0}});

endmodule

// File: rtl/meas_sequencer.sv
// Measurement command sequencer: launches the F or T engine, then the serial
// transmitter, with every wait phase bounded by a shared watchdog.
module meas_sequencer
   import meas_pkg::*;
#(
   parameter int ACK_CYCLES = 16,
   parameter int RUN_CYCLES = 2**26
) (
   input logic              clk,
   input logic              rst,
   meas_sequencer_if.slave  bus
);

   localparam int WD_W = $clog2(RUN_CYCLES + 1);
   // Loaded with N-1 so the abort lands exactly N cycles after entering a wait state.
   localparam logic [WD_W-1:0] ACK_LOAD = WD_W'(ACK_CYCLES - 1);
   localparam logic [WD_W-1:0] RUN_LOAD = WD_W'(RUN_CYCLES - 1);

   seq_state_e  r_state;
   logic [1:0]  r_mode;
   logic [1:0]  r_op;
   err_code_e   r_err_code;
   logic        r_ready;
   logic        r_fstart;
   logic        r_tstart;
   logic        r_cstart;
   logic        r_done;
   logic        r_err;

   seq_state_e  w_next;
   logic [1:0]  w_next_mode;
   logic [1:0]  w_next_op;
   err_code_e   w_next_code;
   logic        w_done;
   logic        w_err;
   logic        w_load;
   logic [WD_W-1:0] w_load_val;
   logic        w_expired;
   logic        w_eng_busy;

   seq_watchdog #(.W(WD_W)) u_wdog (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_expired  (w_expired)
   );

   assign w_eng_busy = uses_f_engine(r_mode) ? bus.Fbusy : bus.Tbusy;

   // Next-state, watchdog reload and pulse decisions.
   always_comb begin
      w_next      = r_state;
      w_next_mode = r_mode;
      w_next_op   = r_op;
      w_next_code = r_err_code;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_load      = 1'b0;
      w_load_val  = ACK_LOAD;
      case (r_state)
         IDLE: begin
            if (bus.cmd_valid) begin
               w_next_op   = bus.cmd_op;
               w_next_mode = (bus.cmd_op == OP_SWEEP) ? MODE_FREQ : bus.cmd_op;
               w_next_code = ERR_NONE;
               w_next      = M_START;
            end else begin
               w_next = IDLE;
            end
         end
         M_START: begin
            w_load     = 1'b1;
            w_load_val = ACK_LOAD;
            w_next     = M_ACK;
         end
         M_ACK: begin
            if (w_eng_busy) begin
               w_load     = 1'b1;
               w_load_val = RUN_LOAD;
               w_next     = M_RUN;
            end else if (w_expired) begin
               w_err       = 1'b1;
               w_next_code = ERR_ACK;
               w_next      = IDLE;
            end else begin
               w_next = M_ACK;
            end
         end
         M_RUN: begin
            // Busy falling on the expiry cycle still counts as a clean finish.
            if (!w_eng_busy) begin
               w_next = C_START;
            end else if (w_expired) begin
               w_err       = 1'b1;
               w_next_code = ERR_RUN;
               w_next      = IDLE;
            end else begin
               w_next = M_RUN;
            end
         end
         C_START: begin
            w_load     = 1'b1;
            w_load_val = ACK_LOAD;
            w_next     = C_ACK;
         end
         C_ACK: begin
            if (bus.Cbusy) begin
               w_load     = 1'b1;
               w_load_val = RUN_LOAD;
               w_next     = C_RUN;
            end else if (w_expired) begin
               w_err       = 1'b1;
               w_next_code = ERR_SERIAL;
               w_next      = IDLE;
            end else begin
               w_next = C_ACK;
            end
         end
         C_RUN: begin
            if (!bus.Cbusy) begin
               w_next = NEXT;
            end else if (w_expired) begin
               w_err       = 1'b1;
               w_next_code = ERR_SERIAL;
               w_next      = IDLE;
            end else begin
               w_next = C_RUN;
            end
         end
         NEXT: begin
            if ((r_op == OP_SWEEP) && (r_mode < MODE_INTERVAL)) begin
               w_next_mode = r_mode + 2'd1;
               w_next      = M_START;
            end else begin
               w_done = 1'b1;
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // State and output registers; outputs are decoded from the next state so they align with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_mode     <= MODE_FREQ;
         r_op       <= 2'd0;
         r_err_code <= ERR_NONE;
         r_ready    <= 1'b1;
         r_fstart   <= 1'b0;
         r_tstart   <= 1'b0;
         r_cstart   <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_mode     <= w_next_mode;
         r_op       <= w_next_op;
         r_err_code <= w_next_code;
         r_ready    <= (w_next == IDLE);
         r_fstart   <= (w_next == M_START) &&  uses_f_engine(w_next_mode);
         r_tstart   <= (w_next == M_START) && !uses_f_engine(w_next_mode);
         r_cstart   <= (w_next == C_START);
         r_done     <= w_done;
         r_err      <= w_err;
      end
   end

   assign bus.ready    = r_ready;
   assign bus.mode     = r_mode;
   assign bus.Fstart   = r_fstart;
   assign bus.Tstart   = r_tstart;
   assign bus.Cstart   = r_cstart;
   assign bus.done     = r_done;
   assign bus.err      = r_err;
   assign bus.err_code = r_err_code;

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed bench for meas_sequencer: behavioural engines plus a cycle-stamped event log.
module tb_meas_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   meas_sequencer_if ifc();

   meas_sequencer #(.ACK_CYCLES(16), .RUN_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int a;
   int b;
   int found;

   int f_q[$];
   int t_q[$];
   int c_q[$];
   int done_q[$];
   int err_q[$];
   int mode_q[$];

   int f_lat = 1, f_len = 1, f_rise = 0, f_fall = 0;
   int t_lat = 1, t_len = 1, t_rise = 0, t_fall = 0;
   int c_lat = 1, c_len = 1, c_rise = 0, c_fall = 0;
   bit t_never = 1'b0;
   bit f_stuck = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log and engine models, evaluated mid-cycle.
   always @(negedge clk) begin
      if (ifc.Fstart) f_q.push_back(cyc);
      if (ifc.Tstart) t_q.push_back(cyc);
      if (ifc.Cstart) c_q.push_back(cyc);
      if (ifc.done)   done_q.push_back(cyc);
      if (ifc.err)    err_q.push_back(cyc);
      if (ifc.Fstart || ifc.Tstart) mode_q.push_back(int'(ifc.mode));
      if (rst) begin
         f_rise = 0; f_fall = 0;
         t_rise = 0; t_fall = 0;
         c_rise = 0; c_fall = 0;
      end else begin
         if (ifc.Fstart) begin f_rise = cyc + f_lat; f_fall = f_rise + f_len; end
         if (ifc.Tstart && !t_never) begin t_rise = cyc + t_lat; t_fall = t_rise + t_len; end
         if (ifc.Cstart) begin c_rise = cyc + c_lat; c_fall = c_rise + c_len; end
      end
      ifc.Fbusy = f_stuck || (cyc >= f_rise && cyc < f_fall);
      ifc.Tbusy = (cyc >= t_rise && cyc < t_fall);
      ifc.Cbusy = (cyc >= c_rise && cyc < c_fall);
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int q_at(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   function automatic int outs();
      return int'({ifc.ready, ifc.mode, ifc.Fstart, ifc.Tstart, ifc.Cstart,
                   ifc.done, ifc.err, ifc.err_code});
   endfunction

   task automatic clear_log();
      f_q.delete(); t_q.delete(); c_q.delete();
      done_q.delete(); err_q.delete(); mode_q.delete();
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Presents one command for a single edge; returns the cycle following acceptance.
   task automatic send_cmd(input logic [1:0] op, output int acc);
      ifc.cmd_op    = op;
      ifc.cmd_valid = 1'b1;
      @(negedge clk);
      ifc.cmd_valid = 1'b0;
      acc = cyc;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got stalled expected finish");
      $fatal(1);
   end

   localparam int RST_OUTS = 512;

   initial begin
      ifc.cmd_valid = 1'b0;
      ifc.cmd_op    = 2'd0;

      // Reset state
      wait_n(2);
      check_eq("reset_outs", outs(), RST_OUTS);
      rst = 1'b0;
      wait_n(2);
      check_eq("idle_outs", outs(), RST_OUTS);

      // Op 0, F busy cycles start+1..start+4
      f_lat = 1; f_len = 4; c_lat = 1; c_len = 2;
      clear_log();
      send_cmd(2'd0, a);
      check_eq("A_ready_low", int'(ifc.ready), 0);
      check_eq("A_fstart_now", int'(ifc.Fstart), 1);
      wait_n(14);
      check_eq("A_f_count", f_q.size(), 1);
      check_eq("A_f_cycle", q_at(f_q, 0), a);
      check_eq("A_t_count", t_q.size(), 0);
      check_eq("A_c_cycle", q_at(c_q, 0), a + 6);
      check_eq("A_done_cycle", q_at(done_q, 0), a + 11);
      check_eq("A_err_count", err_q.size(), 0);
      check_eq("A_err_code", int'(ifc.err_code), 0);
      check_eq("A_ready_back", int'(ifc.ready), 1);

      // Sweep, every engine busy 3 cycles
      f_len = 3; t_len = 3; c_len = 3;
      clear_log();
      send_cmd(2'd3, a);
      wait_n(40);
      check_eq("B_f_count", f_q.size(), 1);
      check_eq("B_t_count", t_q.size(), 2);
      check_eq("B_t0_cycle", q_at(t_q, 0), a + 11);
      check_eq("B_t1_cycle", q_at(t_q, 1), a + 22);
      check_eq("B_c_count", c_q.size(), 3);
      check_eq("B_c2_cycle", q_at(c_q, 2), a + 27);
      check_eq("B_done_count", done_q.size(), 1);
      check_eq("B_done_cycle", q_at(done_q, 0), a + 33);
      for (int i = 0; i < 3; i++) check_eq("B_mode_seq", q_at(mode_q, i), i);

      // Op 1, T engine never acknowledges
      t_never = 1'b1;
      clear_log();
      send_cmd(2'd1, a);
      wait_n(22);
      check_eq("C_err_count", err_q.size(), 1);
      check_eq("C_err_cycle", q_at(err_q, 0), a + 17);
      check_eq("C_err_code", int'(ifc.err_code), 1);
      check_eq("C_ready", int'(ifc.ready), 1);
      check_eq("C_c_count", c_q.size(), 0);
      check_eq("C_done_count", done_q.size(), 0);
      t_never = 1'b0;

      // F busy stuck high: run timeout, then a sweep that must stop after F
      f_stuck = 1'b1;
      clear_log();
      send_cmd(2'd0, a);
      check_eq("D_code_cleared", int'(ifc.err_code), 0);
      wait_n(14);
      check_eq("D_err_cycle", q_at(err_q, 0), a + 10);
      check_eq("D_err_code", int'(ifc.err_code), 2);
      clear_log();
      send_cmd(2'd3, b);
      wait_n(40);
      check_eq("D_sw_err_cycle", q_at(err_q, 0), b + 10);
      check_eq("D_sw_t_count", t_q.size(), 0);
      check_eq("D_sw_c_count", c_q.size(), 0);
      check_eq("D_sw_err_code", int'(ifc.err_code), 2);
      f_stuck = 1'b0;
      wait_n(2);

      // Asynchronous reset during C_RUN, then op 2
      t_len = 1; c_len = 6;
      clear_log();
      send_cmd(2'd1, a);
      wait_n(6);
      check_eq("E_mode_pre", int'(ifc.mode), 1);
      check_eq("E_ready_pre", int'(ifc.ready), 0);
      #2 rst = 1'b1;
      #1 check_eq("E_async_rst", outs(), RST_OUTS);
      wait_n(2);
      rst = 1'b0;
      check_eq("E_c_count", c_q.size(), 1);
      check_eq("E_done_count", done_q.size(), 0);
      t_len = 2; c_len = 2;
      clear_log();
      send_cmd(2'd2, b);
      check_eq("E_mode2", int'(ifc.mode), 2);
      wait_n(12);
      check_eq("E_t_cycle", q_at(t_q, 0), b);
      check_eq("E_f_count", f_q.size(), 0);
      check_eq("E_c_cycle", q_at(c_q, 0), b + 4);
      check_eq("E_done_cycle", q_at(done_q, 0), b + 9);
      check_eq("E_err_code", int'(ifc.err_code), 0);

      // cmd_valid held; Cbusy falls exactly on the expiry cycle
      f_len = 1; c_len = 8;
      clear_log();
      ifc.cmd_op    = 2'd0;
      ifc.cmd_valid = 1'b1;
      @(negedge clk);
      a = cyc;
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         @(negedge clk);
         if (ifc.ready) found = 1;
      end
      check_eq("F_ready_seen", found, 1);
      check_eq("F_ready_cycle", cyc, a + 14);
      @(negedge clk);
      ifc.cmd_valid = 1'b0;
      wait_n(20);
      check_eq("F_f_count", f_q.size(), 2);
      check_eq("F_f1_cycle", q_at(f_q, 1), a + 15);
      check_eq("F_done_count", done_q.size(), 2);
      check_eq("F_done1_cycle", q_at(done_q, 1), a + 29);
      check_eq("F_err_count", err_q.size(), 0);

      // Cbusy one cycle too long: serial timeout
      c_len = 9;
      clear_log();
      send_cmd(2'd0, a);
      wait_n(20);
      check_eq("G_c_cycle", q_at(c_q, 0), a + 3);
      check_eq("G_err_cycle", q_at(err_q, 0), a + 13);
      check_eq("G_err_code", int'(ifc.err_code), 3);
      check_eq("G_done_count", done_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
